instruction_sequencer: RTL
==========================

Name: instruction_sequencer

Overview:
- Front end of the multicycle processor: fetches 16-bit instructions from instruction memory and holds the instruction word `iin` stable.
- Drives the 2-bit step counter `Contador` (0..3) consumed by the control unit.
- Owns the program counter and the memory read handshake.
- Handles run/stop and halt.

Parameters:
- ADDR_W, 8, width of the program counter and instruction address.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- Clock  input  1  system clock; all state updates on rising edge.
- Resetn  input  1  asynchronous active-low reset.
- Run  input  1  level; while high, the sequencer keeps fetching and executing.
- MemData  input  16  instruction word from instruction memory.
- MemValid  input  1  MemData valid this cycle; only meaningful while MemRead=1.
- MemRead  output  1  fetch request.
- MemAddr  output  ADDR_W  fetch address, equal to PC.
- iin  output  16  latched instruction, stable for the whole execution.
- Contador  output  2  execution step, 0..3.
- Done  output  1  one-cycle pulse in the last step of each instruction.
- Busy  output  1  high in FETCH or EXEC.
- Halted  output  1  high in HALT.

Behaviour:
- Reset values (asynchronous, Resetn=0):
  - state=IDLE, PC=RESET_PC, iin=16'h0000, Contador=0.
  - MemRead=0, Done=0, Busy=0, Halted=0.
  - Reset mid-fetch or mid-execution aborts immediately; no partial update survives.
- IDLE:
  - MemRead=0, Contador=0.
  - Run=1 at an edge -> FETCH.
- FETCH:
  - MemRead=1, MemAddr=PC, both held stable until MemValid.
  - MemValid=0 -> stay; Contador=0 and iin unchanged.
  - MemValid=1 -> at that edge: PC<=PC+1 (wraps modulo 2^ADDR_W), then:
    - MemData[15:13]=3'b110 (HLT) -> HALT; iin not updated.
    - Any other opcode (including unused 011) -> iin<=MemData, Contador<=0, go to EXEC.
- EXEC:
  - MemRead=0; Contador advances 0->1->2->3, one step per cycle; iin held constant.
  - Each instruction therefore spends exactly 4 cycles in EXEC.
  - Done=1 exactly while Contador=3.
  - At the edge leaving Contador=3:
    - Run=1 -> FETCH; Contador<=0.
    - Run=0 -> IDLE; Contador<=0.
  - Run falling mid-instruction does not abort it; the current instruction always completes.
- HALT:
  - Halted=1, MemRead=0, Contador=0; Run ignored.
  - Exit only via Resetn.
- Latency:
  - Minimum 1 cycle FETCH (MemValid in the first request cycle) + 4 EXEC cycles = 5 cycles per instruction.
  - MemValid stalls add cycles in FETCH only.
- Simultaneous events:
  - MemValid while not in FETCH is ignored.
  - Run rising during HALT is ignored.
  - PC wrap from all-ones to 0 is silent.
- Busy = (state==FETCH || state==EXEC).

Optional Feature:
- Macro: STEP_DEBUG_EN.
- When defined:
  - Adds input Step (1 bit).
  - In EXEC, Contador advances only on cycles with Step=1; iin and Done hold between steps.
  - Done still asserts only while Contador=3.
  - FETCH behaviour unchanged.
- When undefined:
  - No Step port; Contador advances every cycle as above.

Decomposition:
- Shared package `cpu_pkg`:
  - Opcode constants: OP_ADD=000, OP_SUB=001, OP_NAND=010, OP_OUT=100, OP_LDI=101, OP_HLT=110, OP_REP=111.
  - Instruction field positions: opcode [15:13], rx [12:10], ry [9:7], imm [9:0].
  - State enum: IDLE, FETCH, EXEC, HALT.
  - Step count constant LAST_STEP=2'd3.
- One natural sub-module: `step_counter`, the 2-bit Contador with enable, synchronous clear, and terminal flag. The FSM, PC and iin register stay in the top module.

Test Plan:
- Reset then Run=1; memory returns 16'h0A80 at address 0 with MemValid on the first request cycle -> MemAddr=0; iin=16'h0A80; Contador 0,1,2,3 on the next four cycles; Done=1 only at Contador=3; PC=1.
- MemValid delayed 3 cycles -> MemRead=1 and MemAddr stable for 3 cycles; Contador=0; iin keeps its previous value; then normal 4-step execution.
- Run dropped at Contador=1 -> instruction finishes through Contador=3 with Done pulse; sequencer returns to IDLE; MemRead=0; Busy=0.
- Fetch returns 16'hC000 (HLT) -> Halted=1; iin unchanged; Contador=0; Run=1 has no effect; Resetn pulse -> IDLE with PC=RESET_PC.
- ADDR_W=8, PC=8'hFF, fetch accepted -> PC wraps to 8'h00; next MemAddr=0.
- Resetn asserted at Contador=2 -> all outputs immediately take their reset values; after release with Run=1, the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU front end: opcodes, instruction
// field positions, sequencer states and the execution step count.
package cpu_pkg;

   // Opcode encodings (instruction bits [15:13]); 3'b011 is unused
   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_NAND = 3'b010;
   localparam logic [2:0] OP_OUT  = 3'b100;
   localparam logic [2:0] OP_LDI  = 3'b101;
   localparam logic [2:0] OP_HLT  = 3'b110;
   localparam logic [2:0] OP_REP  = 3'b111;

   // Instruction field positions
   localparam int OPC_HI = 15;
   localparam int OPC_LO = 13;
   localparam int RX_HI  = 12;
   localparam int RX_LO  = 10;
   localparam int RY_HI  = 9;
   localparam int RY_LO  = 7;
   localparam int IMM_HI = 9;
   localparam int IMM_LO = 0;

   // Last execution step of every instruction
   localparam logic [1:0] LAST_STEP = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2,
      HALT  = 2'd3
   } seq_state_t;

   // Extract the opcode field of an instruction word
   function automatic logic [2:0] get_opcode(input logic [15:0] instr);
      return instr[OPC_HI:OPC_LO];
   endfunction

endpackage

// File: rtl/instruction_sequencer_step_counter.sv
// Two-bit execution step counter (Contador) with enable, synchronous clear
// and a terminal flag raised on the last step.
module step_counter
   import cpu_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en_i,
   input  logic       clr_i,
   output logic [1:0] count_o,
   output logic       last_o
);

   logic [1:0] count_q;
   logic [1:0] count_d;

   // Clear wins over enable; advancing past the last step wraps back to 0
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = 2'd0;
      end else if (en_i) begin
         count_d = count_q + 2'd1;
      end
   end

   // Step register, cleared asynchronously by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= 2'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign last_o  = (count_q == LAST_STEP);

endmodule

// File: rtl/instruction_sequencer.sv
// Instruction sequencer: fetches 16-bit instructions, holds iin stable and
// drives the 4-step Contador for the control unit. Owns PC, run/stop, halt.
// Optional macro STEP_DEBUG_EN adds a Step input that gates EXEC progress.
module instruction_sequencer
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
)
(
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              Run,
`ifdef STEP_DEBUG_EN
   input  logic              Step,
`endif
   input  logic [15:0]       MemData,
   input  logic              MemValid,
   output logic              MemRead,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [15:0]       iin,
   output logic [1:0]        Contador,
   output logic              Done,
   output logic              Busy,
   output logic              Halted
);

   localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   seq_state_t        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [15:0]       iin_q, iin_d;

   logic step_en;
   logic cnt_clr;
   logic cnt_last;

`ifdef STEP_DEBUG_EN
   assign step_en = Step;
`else
   assign step_en = 1'b1;
`endif

   // Counter only runs in EXEC; every other state forces it to 0
   assign cnt_clr = (state_q != EXEC);

   step_counter u_step (
      .clk     (Clock),
      .rst_n   (Resetn),
      .en_i    (step_en),
      .clr_i   (cnt_clr),
      .count_o (Contador),
      .last_o  (cnt_last)
   );

   // Next-state, PC and instruction latch decisions
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      iin_d   = iin_q;
      unique case (state_q)
         IDLE: begin
            if (Run) begin
               state_d = FETCH;
            end
         end
         FETCH: begin
            if (MemValid) begin
               pc_d = pc_q + PC_ONE;
               if (get_opcode(MemData) == OP_HLT) begin
                  // HLT is consumed here and never reaches iin
                  state_d = HALT;
               end else begin
                  iin_d   = MemData;
                  state_d = EXEC;
               end
            end
         end
         EXEC: begin
            // Run is only sampled once the instruction has finished
            if (step_en && cnt_last) begin
               state_d = Run ? FETCH : IDLE;
            end
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, PC and instruction registers
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         iin_q   <= 16'h0000;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         iin_q   <= iin_d;
      end
   end

   assign MemRead = (state_q == FETCH);
   assign MemAddr = pc_q;
   assign iin     = iin_q;
   assign Done    = (state_q == EXEC) && cnt_last;
   assign Busy    = (state_q == FETCH) || (state_q == EXEC);
   assign Halted  = (state_q == HALT);

endmodule
